// File: rtl/ascon_text_loader_if.sv
// Bus bundle between the text loader and its host/engine environment.
// The slave modport is the loader's view; the master modport is the environment's view.
interface ascon_text_loader_if;
    logic         start;
    logic         mode_i;
    logic [31:0]  length_i;
    logic         abort;
    logic [31:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] blk_data;
    logic         process_en;
    logic         process_mode_sel;
    logic [31:0]  text_length;
    logic [31:0]  text_position;
    logic [127:0] eng_data_out;
    logic         out_valid;
    logic [127:0] out_data;
    logic [4:0]   out_bytes;
    logic         busy;
    logic         done;
    logic         start_err;

    modport slave (
        input  start, mode_i, length_i, abort, din, din_valid, eng_data_out,
        output din_ready, blk_data, process_en, process_mode_sel, text_length,
               text_position, out_valid, out_data, out_bytes, busy, done, start_err
    );

    modport master (
        output start, mode_i, length_i, abort, din, din_valid, eng_data_out,
        input  din_ready, blk_data, process_en, process_mode_sel, text_length,
               text_position, out_valid, out_data, out_bytes, busy, done, start_err
    );
endinterface

// File: rtl/ascon_text_loader.sv
// Gathers 32-bit text words into 128-bit blocks, issues each block to the
// cipher engine and returns the engine result with its valid byte count.
module ascon_text_loader (
    input  logic                 clk,
    input  logic                 rst,
    ascon_text_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_mode;
    logic [31:0]    r_len;
    logic [31:0]    r_pos;
    logic [127:0]   r_blk;
    logic [2:0]     r_wcnt;
    logic [127:0]   r_out_data;
    logic [4:0]     r_out_bytes;

    logic [31:0]    w_rem;
    logic           w_final;
    logic [2:0]     w_need;
    logic [4:0]     w_out_bytes;
    logic           w_can_take;
    logic           w_xfer;
    logic           w_load_done;
    logic           w_process_en;
    logic           w_out_valid;
    logic           w_done;
    logic           w_start_err;

    // Unsigned wrap is intentional: position never exceeds length in normal flow.
    assign w_rem       = r_len - r_pos;
    assign w_final     = (w_rem <= 32'd16);
    assign w_need      = w_final ? 3'((w_rem[4:0] + 5'd3) >> 2) : 3'd4;
    assign w_out_bytes = w_final ? w_rem[4:0] : 5'd16;

    // Abort drops any word offered in the same cycle.
    assign w_can_take  = (r_state == S_LOAD) && !bus.abort && (r_wcnt < w_need);
    assign w_xfer      = w_can_take && bus.din_valid;
    assign w_load_done = (r_wcnt >= w_need) || (w_xfer && ((r_wcnt + 3'd1) == w_need));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode; abort wins over everything except reset.
    always_comb begin
        w_state_nxt  = r_state;
        w_process_en = 1'b0;
        w_out_valid  = 1'b0;
        w_done       = 1'b0;
        w_start_err  = bus.start && !bus.abort && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_load_done) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_ISSUE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_process_en = 1'b1;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_out_valid = 1'b1;
                    w_done      = w_final;
                    w_state_nxt = w_final ? S_IDLE : S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Message context, block assembly and result capture.
    always_ff @(posedge clk) begin
        if (rst || (bus.abort && (r_state != S_IDLE))) begin
            r_mode      <= 1'b0;
            r_len       <= 32'd0;
            r_pos       <= 32'd0;
            r_blk       <= 128'd0;
            r_wcnt      <= 3'd0;
            r_out_data  <= 128'd0;
            r_out_bytes <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode_i;
                        r_len  <= bus.length_i;
                        r_pos  <= 32'd0;
                        r_blk  <= 128'd0;
                        r_wcnt <= 3'd0;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        for (int k = 0; k < 4; k++) begin
                            if (r_wcnt == 3'(k)) begin
                                r_blk[32*k +: 32] <= bus.din;
                            end
                        end
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                end
                S_WAIT: begin
                    r_out_data  <= bus.eng_data_out;
                    r_out_bytes <= w_out_bytes;
                end
                S_EMIT: begin
                    // Next block starts from an all-zero buffer so short tails stay zero-padded.
                    if (!w_final) begin
                        r_pos  <= r_pos + 32'd16;
                        r_blk  <= 128'd0;
                        r_wcnt <= 3'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.din_ready        = w_can_take;
    assign bus.blk_data         = r_blk;
    assign bus.process_en       = w_process_en;
    assign bus.process_mode_sel = r_mode;
    assign bus.text_length      = r_len;
    assign bus.text_position    = r_pos;
    assign bus.out_valid        = w_out_valid;
    assign bus.out_data         = r_out_data;
    assign bus.out_bytes        = r_out_bytes;
    assign bus.busy             = (r_state != S_IDLE);
    assign bus.done             = w_done;
    assign bus.start_err        = w_start_err;

endmodule

// File: tb/tb_ascon_text_loader.sv
// Randomized bench for ascon_text_loader: a message-level model predicts every
// block, its position, the engine result and byte count, and the done pulse.
module tb_ascon_text_loader;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ascon_text_loader_if bus_if();

    ascon_text_loader u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    function automatic logic [127:0] eng_f(input logic [127:0] x, input logic [127:0] k);
        return {x[63:0], x[127:64]} ^ k;
    endfunction

    // Drives one message and checks every issued block and every result against the model.
    task automatic run_message(input string tag, input int len, input bit mode,
                               input int valid_pct, input int err_at, input bit seq_words);
        logic [31:0]  words[$];
        logic [127:0] blks[$];
        int           obytes[$];
        int           cum[$];
        logic [127:0] blk, key, saved, exp_d;
        logic [31:0]  w;
        int           nblk, rem, nb, nw, tot, widx, bi, ei, cyc, pe_cyc, j;
        bit           pend, fin;

        nblk = (len == 0) ? 1 : (len + 15) / 16;
        tot  = 0;
        for (int b = 0; b < nblk; b++) begin
            rem = len - 16 * b;
            nb  = (rem > 16) ? 16 : rem;
            nw  = (nb + 3) / 4;
            blk = '0;
            for (int k = 0; k < nw; k++) begin
                j = words.size();
                w = seq_words ? {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)} : $urandom;
                words.push_back(w);
                blk[32*k +: 32] = w;
            end
            tot += nw;
            blks.push_back(blk);
            obytes.push_back(nb);
            cum.push_back(tot);
        end
        key    = {$urandom, $urandom, $urandom, $urandom};
        saved  = '0;
        widx   = 0; bi = 0; ei = 0; cyc = 0; pe_cyc = -100;
        pend   = 1'b0; fin = 1'b0;

        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.mode_i    = mode;
        bus_if.length_i  = 32'(len);
        bus_if.din_valid = 1'b0;
        bus_if.abort     = 1'b0;
        #1;
        n_tests++;
        if (bus_if.start_err !== 1'b0 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_start: start_err=%b busy=%b expected 0 0", tag, bus_if.start_err, bus_if.busy);
        end

        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus_if.start = 1'b0;
            bus_if.eng_data_out = pend ? eng_f(saved, key) : {$urandom, $urandom, $urandom, $urandom};
            pend = 1'b0;

            if (bus_if.process_en === 1'b1) begin
                n_tests++;
                if (bi >= nblk) begin
                    n_fail++;
                    $display("FAIL %s extra_block: block %0d issued, expected %0d blocks", tag, bi, nblk);
                end else begin
                    if (bus_if.blk_data !== blks[bi] || bus_if.text_position !== 32'(16*bi) ||
                        bus_if.text_length !== 32'(len) || bus_if.process_mode_sel !== mode) begin
                        n_fail++;
                        $display("FAIL %s issue[%0d]: blk=%h pos=%0d len=%0d mode=%b expected blk=%h pos=%0d len=%0d mode=%b",
                                 tag, bi, bus_if.blk_data, bus_if.text_position, bus_if.text_length,
                                 bus_if.process_mode_sel, blks[bi], 16*bi, len, mode);
                    end
                    n_tests++;
                    if (widx != cum[bi]) begin
                        n_fail++;
                        $display("FAIL %s words_before_issue[%0d]: got %0d expected %0d", tag, bi, widx, cum[bi]);
                    end
                end
                saved  = bus_if.blk_data;
                pend   = 1'b1;
                pe_cyc = cyc;
                bi++;
            end

            if (bus_if.out_valid === 1'b1) begin
                n_tests++;
                if (ei >= nblk) begin
                    n_fail++;
                    $display("FAIL %s extra_result: result %0d, expected %0d", tag, ei, nblk);
                end else begin
                    exp_d = eng_f(blks[ei], key);
                    if (bus_if.out_data !== exp_d || bus_if.out_bytes !== 5'(obytes[ei]) ||
                        bus_if.done !== (ei == nblk - 1) || (cyc - pe_cyc) != 2) begin
                        n_fail++;
                        $display("FAIL %s result[%0d]: data=%h bytes=%0d done=%b lat=%0d expected data=%h bytes=%0d done=%b lat=2",
                                 tag, ei, bus_if.out_data, bus_if.out_bytes, bus_if.done, cyc - pe_cyc,
                                 exp_d, obytes[ei], (ei == nblk - 1));
                    end
                end
                if (bus_if.done === 1'b1) fin = 1'b1;
                ei++;
            end else if (bus_if.done === 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s done_without_valid: done=1 expected 0", tag);
                fin = 1'b1;
            end

            if (cyc == err_at) begin
                bus_if.start    = 1'b1;
                bus_if.length_i = 32'(len + 7);
                bus_if.mode_i   = ~mode;
            end
            bus_if.din_valid = ($urandom_range(0, 99) < valid_pct);
            bus_if.din       = (widx < words.size()) ? words[widx] : $urandom;
            #1;
            if (cyc == err_at) begin
                n_tests++;
                if (bus_if.start_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s start_err: got %b expected 1", tag, bus_if.start_err);
                end
            end
            if (bus_if.din_valid && bus_if.din_ready === 1'b1) begin
                if (widx >= words.size()) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s extra_word: word %0d accepted, expected %0d", tag, widx, words.size());
                end
                widx++;
            end
        end
        bus_if.start     = 1'b0;
        bus_if.din_valid = 1'b0;
        n_tests++;
        if (!fin || ei != nblk || widx != tot) begin
            n_fail++;
            $display("FAIL %s completion: done=%b results=%0d words=%0d expected done=1 results=%0d words=%0d",
                     tag, fin, ei, widx, nblk, tot);
        end
    endtask

    // Reset must leave every output at zero.
    task automatic test_reset();
        rst                 = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.mode_i       = 1'b0;
        bus_if.length_i     = 32'd0;
        bus_if.abort        = 1'b0;
        bus_if.din          = 32'd0;
        bus_if.din_valid    = 1'b0;
        bus_if.eng_data_out = 128'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus_if.busy, bus_if.din_ready, bus_if.process_en, bus_if.out_valid, bus_if.done,
             bus_if.start_err, bus_if.process_mode_sel, bus_if.out_bytes, bus_if.text_length,
             bus_if.text_position, bus_if.blk_data, bus_if.out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b rdy=%b pe=%b ov=%b done=%b len=%0d pos=%0d blk=%h expected all 0",
                     bus_if.busy, bus_if.din_ready, bus_if.process_en, bus_if.out_valid, bus_if.done,
                     bus_if.text_length, bus_if.text_position, bus_if.blk_data);
        end
        rst = 1'b0;
    endtask

    // Directed lengths: empty, single full block, full+1 word, three blocks with gaps.
    task automatic test_lengths();
        run_message("len0",  0,  1'b0, 100, -1, 1'b0);
        run_message("len16", 16, 1'b1, 100, -1, 1'b1);
        run_message("len20", 20, 1'b0, 70,  -1, 1'b0);
        run_message("len37", 37, 1'b1, 45,  -1, 1'b0);
    endtask

    // A start pulse mid-message is flagged and ignored.
    task automatic test_start_err();
        run_message("start_err", 37, 1'b0, 60, 3, 1'b0);
    endtask

    // Cancel (abort or reset) after two words, then a short message must run cleanly.
    task automatic test_abort(input bit use_rst);
        int got;
        got = 0;
        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.length_i  = 32'd48;
        bus_if.mode_i    = 1'b1;
        bus_if.din_valid = 1'b0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            bus_if.start     = 1'b0;
            bus_if.din_valid = 1'b1;
            bus_if.din       = $urandom;
            #1;
            if (bus_if.din_ready === 1'b1) got++;
        end
        n_tests++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL cancel_preload: words=%0d expected 2", got);
        end
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else bus_if.abort = 1'b1;
        bus_if.din_valid = 1'b1;
        bus_if.din       = $urandom;
        #1;
        if (!use_rst) begin
            n_tests++;
            if (bus_if.din_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_drop: din_ready=%b expected 0", bus_if.din_ready);
            end
        end
        @(negedge clk);
        rst              = 1'b0;
        bus_if.abort     = 1'b0;
        bus_if.din_valid = 1'b0;
        n_tests++;
        if ({bus_if.busy, bus_if.din_ready, bus_if.process_en, bus_if.out_valid, bus_if.done,
             bus_if.process_mode_sel, bus_if.out_bytes, bus_if.text_length,
             bus_if.text_position, bus_if.blk_data, bus_if.out_data} !== '0) begin
            n_fail++;
            $display("FAIL cancel_outputs(rst=%b): busy=%b pe=%b ov=%b len=%0d pos=%0d blk=%h expected all 0",
                     use_rst, bus_if.busy, bus_if.process_en, bus_if.out_valid,
                     bus_if.text_length, bus_if.text_position, bus_if.blk_data);
        end
        run_message(use_rst ? "after_rst" : "after_abort", 4, 1'b0, 100, -1, 1'b0);
    endtask

    // Random messages started immediately after the previous done.
    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_message("b2b", $urandom_range(0, 80), 1'($urandom_range(0, 1)),
                        $urandom_range(30, 100), -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_lengths();
        test_start_err();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
